mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  launch request, sampled on the rising edge of clk.
REQ-005 op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 a  input  32  operand A: rs value, multiplicand or dividend.
REQ-007 b  input  32  operand B: rt value, multiplier or divisor.
REQ-008 hi_we  input  1  mthi write strobe.
REQ-009 lo_we  input  1  mtlo write strobe.
REQ-010 wdata  input  32  mthi/mtlo write data.
REQ-011 busy  output  1  high while an operation is in flight.
REQ-012 done  output  1  one-cycle pulse when HI/LO take a result.
REQ-013 hi  output  32  HI register, read directly by mfhi.
REQ-014 lo  output  32  LO register, read directly by mflo.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-016 In IDLE with start=1, the block SHALL do the following on the same edge:
- latch a, b and op;
- clear a 5-bit iteration counter;
- move to RUN and set busy=1.
REQ-017 RUN SHALL execute exactly 32 iterations, one per cycle:
- multiply: radix-2 shift-add;
- divide: radix-2 restoring;
- then move to FIN.
REQ-018 Signed operations SHALL run on operand magnitudes and fix the result sign in FIN.
REQ-019 On the FIN edge the block SHALL write HI/LO, pulse done=1 for one cycle, clear busy and return to IDLE.
REQ-020 Latency SHALL be fixed: start sampled at edge N gives done=1 and valid HI/LO during the cycle after edge N+33.
REQ-021 busy SHALL be high from edge N through edge N+33.
REQ-022 Result mapping:
- multiply: {HI,LO} = 64-bit product, two's complement for mult;
- divide: LO = quotient, HI = remainder.
REQ-023 Signed division SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero (b=0, div or divu) SHALL give HI=a and LO=32'hFFFFFFFF and keep the same 34-cycle latency.
REQ-025 div with a=32'h80000000 and b=32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0.
REQ-026 start while busy=1 SHALL be ignored and SHALL NOT disturb the operation in flight.
REQ-027 hi_we/lo_we while busy=1 SHALL be ignored.
REQ-028 In IDLE, hi_we/lo_we SHALL write wdata into HI/LO on the edge; both strobes high SHALL write both registers.
REQ-029 In IDLE, start together with hi_we/lo_we SHALL apply the write and launch the operation; the later result SHALL overwrite HI/LO.
REQ-030 hi and lo SHALL hold their last value at all times except on a FIN edge or an accepted write.

Reset
REQ-031 rst=0 SHALL immediately force the following, independent of clk:
- state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
REQ-032 Reset asserted mid-operation SHALL abort it with no HI/LO update; the first edge after release SHALL accept a new start.

Verification
REQ-033 multu a=32'hFFFFFFFF, b=32'hFFFFFFFF -> after 34 cycles HI=32'hFFFFFFFE, LO=32'h00000001, done pulses once.
REQ-034 mult a=-3 (32'hFFFFFFFD), b=7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
REQ-035 div a=-7, b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; divu a=100, b=0 -> HI=100, LO=32'hFFFFFFFF.
REQ-036 Mid-operation checks -> HI/LO show only the original result, and a 0 latched just before FIN is not visible:
- second start at cycle 10 of a run is ignored;
- hi_we asserted during RUN with wdata=32'h12345678 is ignored.
REQ-037 Reset pulse at cycle 15 of a div -> busy=0, hi=lo=0 at once, no done; a new multu 6*7 after release -> LO=42, HI=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Operations take 34 cycles: a load edge, 32 radix-2 steps, then a sign-fix/writeback edge.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_d;
  logic [63:0] r_p;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dzero;

  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_add;
  logic [32:0] w_rs;
  logic [32:0] w_diff;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  function automatic logic [31:0] cond_neg32(input logic en, input logic [31:0] v);
    return en ? 32'(-v) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic en, input logic [63:0] v);
    return en ? 64'(-v) : v;
  endfunction

  assign w_signed = ~op[0];
  assign w_a_mag  = cond_neg32(w_signed & a[31], a);
  assign w_b_mag  = cond_neg32(w_signed & b[31], b);

  // r_p holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  assign w_add  = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_d} : 33'd0);
  assign w_rs   = {r_p[63:32], r_p[31]};
  assign w_diff = w_rs - {1'b0, r_d};

  assign w_prod = cond_neg64(r_neg_q, r_p);
  assign w_quo  = cond_neg32(r_neg_q, r_p[31:0]);
  assign w_rem  = cond_neg32(r_neg_r, r_p[63:32]);

  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_op    <= op;
      r_a     <= a;
      r_d     <= w_b_mag;
      r_p     <= {32'd0, w_a_mag};
      r_neg_q <= w_signed & (a[31] ^ b[31]);
      r_neg_r <= w_signed & a[31];
      r_dzero <= (b == 32'd0);
    end else if (r_state == RUN) begin
      if (!r_op[1])
        r_p <= {w_add, r_p[31:1]};
      else if (!w_diff[32])
        r_p <= {w_diff[31:0], r_p[30:0], 1'b1};
      else
        r_p <= {w_rs[31:0], r_p[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_state <= RUN;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= FIN;
        end
        FIN: begin
          if (!r_op[1]) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_dzero) begin
            r_hi <= r_a;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes model results, negedge monitor checks them.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ehi;
    logic [31:0] elo;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV signed / and % already truncate toward zero
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return 64'(ux * uy);
      2'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("done_latency", 64'(cyc), 64'(e.due));
          check("result_hilo", {hi, lo}, {e.ehi, e.elo});
          check("busy_at_done", 64'(busy), 64'd0);
          m_hi = e.ehi;
          m_lo = e.elo;
        end
      end else begin
        check("hilo_hold", {hi, lo}, {m_hi, m_lo});
        if (q.size() != 0 && cyc > q[0].due + 2) begin
          check("done_timeout", 64'd0, 64'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic hw, input logic lw, input logic [31:0] wd, output int n);
    logic [63:0] r;
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; hi_we = hw; lo_we = lw; wdata = wd;
    @(posedge clk);
    #1;
    n = cyc;
    r = ref_model(o, x, y);
    e.ehi = r[63:32];
    e.elo = r[31:0];
    e.due = n + 33;
    q.push_back(e);
    if (hw) m_hi = wd;
    if (lw) m_lo = wd;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic do_write(input logic hw, input logic lw, input logic [31:0] wd);
    @(negedge clk);
    hi_we = hw; lo_we = lw; wdata = wd;
    @(posedge clk);
    #1;
    if (hw) m_hi = wd;
    if (lw) m_lo = wd;
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("wait_idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic drive_during_run(input int n, input int at, input logic st,
                                  input logic hw, input logic lw, input logic [31:0] wd);
    while (cyc < n + at) @(negedge clk);
    start = st; op = 2'd1; a = 32'h5; b = 32'h5; hi_we = hw; lo_we = lw; wdata = wd;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    int n;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #3; rst = 1'b1;

    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, n); wait_idle();
    issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 32'd0, n); wait_idle();
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0, n); wait_idle();
    issue(2'd3, 32'd100, 32'd0, 1'b0, 1'b0, 32'd0, n); wait_idle();
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, n); wait_idle();
    issue(2'd2, 32'hFFFF_FF9C, 32'd0, 1'b0, 1'b0, 32'd0, n); wait_idle();
    issue(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0, n); wait_idle();

    do_write(1'b1, 1'b0, 32'hCAFE_0001);
    do_write(1'b0, 1'b1, 32'hCAFE_0002);
    do_write(1'b1, 1'b1, 32'h0BAD_F00D);
    @(negedge clk);

    issue(2'd1, 32'd1234, 32'd5678, 1'b1, 1'b1, 32'hDEAD_BEEF, n);
    wait_idle();

    issue(2'd3, 32'hF000_0000, 32'd3, 1'b0, 1'b0, 32'd0, n);
    drive_during_run(n, 5, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
    drive_during_run(n, 10, 1'b1, 1'b0, 1'b0, 32'd0);
    drive_during_run(n, 32, 1'b0, 1'b1, 1'b1, 32'd0);
    wait_idle();

    issue(2'd2, 32'h7FFF_1234, 32'd77, 1'b0, 1'b0, 32'd0, n);
    while (cyc < n + 15) @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    issue(2'd1, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0, n); wait_idle();

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) do_write(1'($urandom), 1'($urandom), $urandom);
      issue(ro, ra, rb, 1'($urandom), 1'($urandom), $urandom, n);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
